// File: rtl/associative_memory_trainer_pkg.sv
// Shared constants and state encoding for the associative-memory trainer.
package associative_memory_trainer_pkg;

    function automatic int unsigned ceil_log2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) result++;
        return result;
    endfunction

    localparam int unsigned HvDimension     = 2000;
    localparam int unsigned AmChunk         = 250;
    localparam int unsigned AmCycleLoop     = HvDimension / AmChunk;
    localparam int unsigned LabelWidth      = 2;
    localparam int unsigned TrainCountWidth = 6;
    localparam int unsigned MaxSamples      = (1 << TrainCountWidth) - 1;
    // Chunk down-counter holds L..1, so it needs room for L itself.
    localparam int unsigned ChunkCntWidth   = ceil_log2(AmCycleLoop + 1);

    typedef enum logic [1:0] {
        StIdle         = 2'd0,
        StAccum        = 2'd1,
        StThresh       = 2'd2,
        StOutputStable = 2'd3
    } state_e;

endpackage

// File: rtl/am_train_counter_bank.sv
// One chunk of per-bit saturating bundle counters plus the majority/tie threshold.
module am_train_counter_bank
    import associative_memory_trainer_pkg::*;
#(
    parameter int unsigned Chunk    = AmChunk,
    parameter int unsigned CntWidth = TrainCountWidth
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                inc_en,
    input  logic [0:Chunk-1]    sample_bits,
    input  logic [CntWidth-1:0] sample_count,
    output logic [0:Chunk-1]    majority
);

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    logic [CntWidth-1:0] cnt_q [Chunk];
    logic [CntWidth:0]   total;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < Chunk; j++) cnt_q[j] <= '0;
        end else if (clear) begin
            for (int j = 0; j < Chunk; j++) cnt_q[j] <= '0;
        end else if (inc_en) begin
            for (int j = 0; j < Chunk; j++) begin
                if (sample_bits[j] && (cnt_q[j] != CntMax)) cnt_q[j] <= cnt_q[j] + CntOne;
            end
        end
    end

    assign total = {1'b0, sample_count};

    // Compare 2*count against the sample count one bit wider so nothing overflows.
    for (genvar j = 0; j < Chunk; j++) begin : g_cmp
        logic [CntWidth:0] twice;
        assign twice       = {cnt_q[j], 1'b0};
        assign majority[j] = (twice == total) ? sample_bits[j] : (twice > total);
    end

endmodule

// File: rtl/associative_memory_trainer.sv
// Bundles labelled training hypervectors into one class prototype per session.
module associative_memory_trainer
    import associative_memory_trainer_pkg::*;
(
    input  logic                       Clk_CI,
    input  logic                       Reset_RI,
    input  logic                       ValidIn_SI,
    output logic                       ReadyOut_SO,
    input  logic [0:HvDimension-1]     HypervectorIn_DI,
    input  logic [LabelWidth-1:0]      LabelIn_DI,
    input  logic                       LastIn_SI,
    output logic                       ValidOut_SO,
    input  logic                       ReadyIn_SI,
    output logic [0:HvDimension-1]     ClassOut_DO,
    output logic [LabelWidth-1:0]      LabelOut_DO,
    output logic [TrainCountWidth-1:0] SampleCountOut_DO,
    output logic                       LabelErrOut_SO
);

    localparam logic [ChunkCntWidth-1:0]   ChunkFirst = ChunkCntWidth'(AmCycleLoop);
    localparam logic [ChunkCntWidth-1:0]   ChunkOne   = ChunkCntWidth'(1);
    localparam logic [TrainCountWidth-1:0] CountMax   = TrainCountWidth'(MaxSamples);
    localparam logic [TrainCountWidth-1:0] CountOne   = TrainCountWidth'(1);

    state_e                     state_q, state_d;
    logic [ChunkCntWidth-1:0]   chunk_q, chunk_d;
    logic [TrainCountWidth-1:0] sample_cnt_q;
    logic [LabelWidth-1:0]      label_q;
    logic                       label_valid_q;
    logic                       label_err_q;
    logic                       last_q;
    logic [0:HvDimension-1]     hv_q;
    logic [0:HvDimension-1]     class_q;
    logic [LabelWidth-1:0]      label_out_q;
    logic [TrainCountWidth-1:0] count_out_q;

    logic                       label_mismatch;
    logic                       accept;
    logic                       drop;
    logic                       last_chunk;
    logic                       finalize;
    logic                       bank_clear;
    logic [AmCycleLoop-1:0]     bank_sel;
    logic [0:HvDimension-1]     majority;

    assign label_mismatch = label_valid_q && (LabelIn_DI != label_q);
    assign accept         = (state_q == StIdle) && ValidIn_SI && !label_mismatch;
    assign drop           = (state_q == StIdle) && ValidIn_SI && label_mismatch;
    assign last_chunk     = (chunk_q == ChunkOne);
    assign finalize       = last_q || (sample_cnt_q == CountMax);
    assign bank_clear     = (state_q == StOutputStable) && ReadyIn_SI;

    for (genvar k = 0; k < AmCycleLoop; k++) begin : g_bank
        // Chunk k is active while the down-counter reads L-k.
        assign bank_sel[k] = (chunk_q == ChunkCntWidth'(AmCycleLoop - k));

        am_train_counter_bank #(
            .Chunk    (AmChunk),
            .CntWidth (TrainCountWidth)
        ) u_bank (
            .clk          (Clk_CI),
            .rst          (Reset_RI),
            .clear        (bank_clear),
            .inc_en       ((state_q == StAccum) && bank_sel[k]),
            .sample_bits  (hv_q[k*AmChunk +: AmChunk]),
            .sample_count (sample_cnt_q),
            .majority     (majority[k*AmChunk +: AmChunk])
        );
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_q <= StIdle;
            chunk_q <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StAccum;
                    chunk_d = ChunkFirst;
                end
            end
            StAccum: begin
                chunk_d = chunk_q - ChunkOne;
                if (last_chunk) begin
                    chunk_d = ChunkFirst;
                    state_d = finalize ? StThresh : StIdle;
                end
            end
            StThresh: begin
                chunk_d = chunk_q - ChunkOne;
                if (last_chunk) state_d = StOutputStable;
            end
            StOutputStable: begin
                if (ReadyIn_SI) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            sample_cnt_q  <= '0;
            label_q       <= '0;
            label_valid_q <= 1'b0;
            label_err_q   <= 1'b0;
            last_q        <= 1'b0;
            hv_q          <= '0;
            class_q       <= '0;
            label_out_q   <= '0;
            count_out_q   <= '0;
        end else begin
            if (accept) begin
                hv_q         <= HypervectorIn_DI;
                last_q       <= LastIn_SI;
                sample_cnt_q <= sample_cnt_q + CountOne;
                if (!label_valid_q) begin
                    label_q       <= LabelIn_DI;
                    label_valid_q <= 1'b1;
                end
            end
            if (drop) label_err_q <= 1'b1;
            if (state_q == StThresh) begin
                for (int k = 0; k < AmCycleLoop; k++) begin
                    if (bank_sel[k]) class_q[k*AmChunk +: AmChunk] <= majority[k*AmChunk +: AmChunk];
                end
                if (last_chunk) begin
                    label_out_q <= label_q;
                    count_out_q <= sample_cnt_q;
                end
            end
            if (bank_clear) begin
                sample_cnt_q  <= '0;
                label_valid_q <= 1'b0;
            end
        end
    end

    // Ready is held low while reset is asserted so every output reads 0 during reset.
    assign ReadyOut_SO       = (state_q == StIdle) && !Reset_RI;
    assign ValidOut_SO       = (state_q == StOutputStable);
    assign ClassOut_DO       = class_q;
    assign LabelOut_DO       = label_out_q;
    assign SampleCountOut_DO = count_out_q;
    assign LabelErrOut_SO    = label_err_q;

endmodule

// File: tb/tb_associative_memory_trainer.sv
// Directed bench with a session-level bundling model checked every cycle.
module tb_associative_memory_trainer;
    import associative_memory_trainer_pkg::*;

    typedef logic [0:HvDimension-1] hv_t;
    localparam int L = AmCycleLoop;

    logic                       Clk_CI = 1'b0;
    logic                       Reset_RI = 1'b1;
    logic                       ValidIn_SI = 1'b0;
    logic                       ReadyOut_SO;
    hv_t                        HypervectorIn_DI = '0;
    logic [LabelWidth-1:0]      LabelIn_DI = '0;
    logic                       LastIn_SI = 1'b0;
    logic                       ValidOut_SO;
    logic                       ReadyIn_SI = 1'b0;
    hv_t                        ClassOut_DO;
    logic [LabelWidth-1:0]      LabelOut_DO;
    logic [TrainCountWidth-1:0] SampleCountOut_DO;
    logic                       LabelErrOut_SO;

    associative_memory_trainer dut (
        .Clk_CI            (Clk_CI),
        .Reset_RI          (Reset_RI),
        .ValidIn_SI        (ValidIn_SI),
        .ReadyOut_SO       (ReadyOut_SO),
        .HypervectorIn_DI  (HypervectorIn_DI),
        .LabelIn_DI        (LabelIn_DI),
        .LastIn_SI         (LastIn_SI),
        .ValidOut_SO       (ValidOut_SO),
        .ReadyIn_SI        (ReadyIn_SI),
        .ClassOut_DO       (ClassOut_DO),
        .LabelOut_DO       (LabelOut_DO),
        .SampleCountOut_DO (SampleCountOut_DO),
        .LabelErrOut_SO    (LabelErrOut_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always @(posedge Clk_CI) cyc = cyc + 1;

    function automatic void chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endfunction

    function automatic void chk_hv(input string name, input hv_t got, input hv_t exp);
        int first;
        first = 0;
        n_total++;
        if (got === exp) begin
            n_pass++;
            return;
        end
        for (int i = HvDimension - 1; i >= 0; i--) if (got[i] !== exp[i]) first = i;
        $display("FAIL %s: bit %0d is %b, expected %b", name, first, got[first], exp[first]);
    endfunction

    // Session model: remembers accepted samples and when outputs must appear.
    hv_t                   samples[$];
    int                    m_edge = 0, m_idle_from = 0, m_valid_at = 0, m_count_out = 0;
    bit                    m_valid = 0, m_fin = 0, m_lv = 0, m_err = 0, m_known = 1;
    logic [LabelWidth-1:0] m_lab = '0, m_label_out = '0;
    hv_t                   m_class = '0;

    function automatic hv_t bundle();
        hv_t r;
        int  n, ones;
        n = samples.size();
        for (int j = 0; j < HvDimension; j++) begin
            ones = 0;
            foreach (samples[s]) ones += int'(samples[s][j]);
            if (2 * ones > n)      r[j] = 1'b1;
            else if (2 * ones < n) r[j] = 1'b0;
            else                   r[j] = samples[n-1][j];
        end
        return r;
    endfunction

    always @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            samples.delete();
            m_valid = 0; m_fin = 0; m_lv = 0; m_err = 0; m_known = 1;
            m_class = '0; m_label_out = '0; m_count_out = 0; m_idle_from = 0;
        end else begin
            m_edge++;
            if (m_valid && ReadyIn_SI) begin
                m_valid = 0;
                m_idle_from = m_edge + 1;
                samples.delete();
                m_lv = 0;
            end else if (!m_valid && !m_fin && m_edge >= m_idle_from && ValidIn_SI) begin
                if (m_lv && LabelIn_DI != m_lab) begin
                    m_err = 1;
                end else begin
                    if (!m_lv) begin
                        m_lv = 1;
                        m_lab = LabelIn_DI;
                    end
                    samples.push_back(HypervectorIn_DI);
                    if (LastIn_SI || samples.size() == MaxSamples) begin
                        m_fin = 1;
                        m_valid_at = m_edge + 2 * L;
                        m_known = 0;
                    end else begin
                        m_idle_from = m_edge + L + 1;
                    end
                end
            end
            if (m_fin && m_edge == m_valid_at) begin
                m_fin = 0;
                m_valid = 1;
                m_known = 1;
                m_class = bundle();
                m_label_out = m_lab;
                m_count_out = samples.size();
            end
        end
    end

    always @(negedge Clk_CI) begin
        if (!Reset_RI) begin
            chk("ready", ReadyOut_SO, (!m_valid && !m_fin && (m_edge + 1 >= m_idle_from)));
            chk("valid", ValidOut_SO, m_valid);
            chk("label_err", LabelErrOut_SO, m_err);
            if (m_known) begin
                chk_hv("class", ClassOut_DO, m_class);
                chk("label_out", LabelOut_DO, m_label_out);
                chk("count_out", SampleCountOut_DO, m_count_out);
            end
        end
    end

    function automatic hv_t rand_hv();
        hv_t r;
        for (int i = 0; i < HvDimension; i++) r[i] = 1'($urandom_range(1, 0));
        return r;
    endfunction

    task automatic send(input hv_t hv, input logic [LabelWidth-1:0] lab, input logic last,
                        output int acc);
        int n;
        n = 0;
        ValidIn_SI = 1'b1;
        HypervectorIn_DI = hv;
        LabelIn_DI = lab;
        LastIn_SI = last;
        while (!ReadyOut_SO && n < 200) begin
            @(posedge Clk_CI); #1;
            n++;
        end
        if (n >= 200) chk("send_timeout", 0, 1);
        @(posedge Clk_CI); #1;
        acc = cyc;
        ValidIn_SI = 1'b0;
        LastIn_SI = 1'b0;
    endtask

    task automatic wait_valid(output int at);
        int n;
        n = 0;
        while (!ValidOut_SO && n < 200) begin
            @(posedge Clk_CI); #1;
            n++;
        end
        if (n >= 200) chk("valid_timeout", 0, 1);
        at = cyc;
    endtask

    task automatic take();
        int at;
        wait_valid(at);
        ReadyIn_SI = 1'b1;
        @(posedge Clk_CI); #1;
        ReadyIn_SI = 1'b0;
    endtask

    hv_t a, b, c, d;
    hv_t ones_hv;
    int  acc, at;

    initial begin
        a = rand_hv();
        b = rand_hv();
        ones_hv = '1;

        repeat (3) @(posedge Clk_CI);
        #1;
        chk("rst_ready", ReadyOut_SO, 0);
        chk("rst_valid", ValidOut_SO, 0);
        chk("rst_err", LabelErrOut_SO, 0);
        chk("rst_count", SampleCountOut_DO, 0);
        Reset_RI = 1'b0;
        #1;
        chk("post_rst_ready", ReadyOut_SO, 1);
        @(posedge Clk_CI); #1;

        // Three samples, majority wins everywhere.
        send(a, 2'd1, 1'b0, acc);
        send(a, 2'd1, 1'b0, acc);
        send(b, 2'd1, 1'b1, acc);
        wait_valid(at);
        chk("t1_latency", at - acc, 2 * L);
        chk_hv("t1_class", ClassOut_DO, a);
        chk("t1_label", LabelOut_DO, 1);
        chk("t1_count", SampleCountOut_DO, 3);
        take();

        // Every bit ties, so the last sample decides.
        send(a, 2'd0, 1'b0, acc);
        send(~a, 2'd0, 1'b1, acc);
        wait_valid(at);
        chk_hv("t2_class", ClassOut_DO, ~a);
        chk("t2_count", SampleCountOut_DO, 2);
        take();

        // Mismatched label dropped.
        c = rand_hv();
        d = rand_hv();
        send(a, 2'd0, 1'b0, acc);
        send(d, 2'd2, 1'b0, acc);
        #1 chk("t3_err_set", LabelErrOut_SO, 1);
        send(c, 2'd0, 1'b1, acc);
        wait_valid(at);
        chk_hv("t3_class", ClassOut_DO, c);
        chk("t3_count", SampleCountOut_DO, 2);
        chk("t3_label", LabelOut_DO, 0);
        take();
        chk("t3_err_sticky", LabelErrOut_SO, 1);

        // Forced finalize at the sample-count ceiling.
        for (int i = 0; i < MaxSamples; i++) send(ones_hv, 2'd3, 1'b0, acc);
        wait_valid(at);
        chk("t4_latency", at - acc, 2 * L);
        chk_hv("t4_class", ClassOut_DO, ones_hv);
        chk("t4_count", SampleCountOut_DO, MaxSamples);

        // Downstream backpressure.
        repeat (10) @(posedge Clk_CI);
        #1;
        chk("t5_valid_held", ValidOut_SO, 1);
        chk("t5_ready_low", ReadyOut_SO, 0);
        chk_hv("t5_class_held", ClassOut_DO, ones_hv);
        chk("t5_count_held", SampleCountOut_DO, MaxSamples);
        ReadyIn_SI = 1'b1;
        @(posedge Clk_CI); #1;
        ReadyIn_SI = 1'b0;
        chk("t5_ready_back", ReadyOut_SO, 1);
        chk_hv("t5_class_after_hs", ClassOut_DO, ones_hv);
        send(b, 2'd2, 1'b1, acc);
        wait_valid(at);
        chk("t5_count", SampleCountOut_DO, 1);
        chk_hv("t5_class", ClassOut_DO, b);
        chk("t5_label", LabelOut_DO, 2);
        take();

        // Asynchronous reset in the middle of accumulation.
        send(a, 2'd1, 1'b0, acc);
        @(posedge Clk_CI);
        @(negedge Clk_CI);
        #1 Reset_RI = 1'b1;
        #1;
        chk("t6_ready", ReadyOut_SO, 0);
        chk("t6_valid", ValidOut_SO, 0);
        chk("t6_err", LabelErrOut_SO, 0);
        chk_hv("t6_class", ClassOut_DO, '0);
        chk("t6_label", LabelOut_DO, 0);
        chk("t6_count", SampleCountOut_DO, 0);
        #1 Reset_RI = 1'b0;
        @(posedge Clk_CI); #1;
        c = rand_hv();
        send(c, 2'd3, 1'b1, acc);
        wait_valid(at);
        chk("t6_latency", at - acc, 2 * L);
        chk_hv("t6_class_new", ClassOut_DO, c);
        chk("t6_count_new", SampleCountOut_DO, 1);
        take();

        repeat (2) @(posedge Clk_CI);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
